// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier request sequencer and its FIFO.
package mul_pkg;

   localparam int WORD_W          = 32;
   localparam int DEFAULT_TIMEOUT = 15;
   localparam int OVF_CNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Saturating increment for the overflow event counter.
   function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] value);
      return (&value) ? value : value + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/mul_req_fifo.sv
// Request buffer: DEPTH entries, pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module mul_req_fifo
   import mul_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2*WORD_W + 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign dout      = mem_r[rd_ptr_r[AW-1:0]];

   // Storage write and pointer advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
            wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/mul_req_sequencer.sv
// Issue stage for the Booth/CSA multiplier: queues tagged operand pairs, runs one
// operation at a time and returns the result, or a timeout error, with its tag.
module mul_req_sequencer
   import mul_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WORD_W-1:0]    req_op1,
   input  logic [WORD_W-1:0]    req_op2,
   input  logic [TAG_W-1:0]     req_tag,
   output logic                 mul_en,
   output logic [WORD_W-1:0]    mul_op1,
   output logic [WORD_W-1:0]    mul_op2,
   input  logic [WORD_W-1:0]    mul_res,
   input  logic                 mul_val,
   input  logic                 mul_ovf,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WORD_W-1:0]    rsp_res,
   output logic                 rsp_ovf,
   output logic                 rsp_err,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic                 busy,
   output logic [OVF_CNT_W-1:0] ovf_count
);

   localparam int         ENTRY_W   = 2*WORD_W + TAG_W;
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

   state_t                 state_r;
   state_t                 state_next_s;
   logic                   fifo_full_s;
   logic                   fifo_empty_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   rsp_hs_s;
   logic                   wdog_expired_s;
   logic                   mul_en_s;
   logic                   rsp_valid_s;
   logic [ENTRY_W-1:0]     fifo_din_s;
   logic [ENTRY_W-1:0]     fifo_dout_s;
   logic [WORD_W-1:0]      op1_r;
   logic [WORD_W-1:0]      op2_r;
   logic [TAG_W-1:0]       tag_r;
   logic [WORD_W-1:0]      rsp_res_r;
   logic                   rsp_ovf_r;
   logic                   rsp_err_r;
   logic [TAG_W-1:0]       rsp_tag_r;
   logic [7:0]             wdog_r;
   logic [OVF_CNT_W-1:0]   ovf_count_r;

   assign push_s         = req_valid & ~fifo_full_s;
   assign rsp_hs_s       = (state_r == RESP) & rsp_ready;
   assign pop_s          = ~fifo_empty_s & ((state_r == IDLE) | rsp_hs_s);
   assign wdog_expired_s = (wdog_r == WDOG_LAST);
   assign fifo_din_s     = {req_tag, req_op2, req_op1};

   mul_req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   (fifo_din_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state; a result arriving on the last watchdog cycle still wins.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    if (!fifo_empty_s) state_next_s = ISSUE; else state_next_s = IDLE;
         ISSUE:   state_next_s = WAIT;
         WAIT:    if (mul_val || wdog_expired_s) state_next_s = RESP; else state_next_s = WAIT;
         RESP: begin
            if (rsp_ready) begin
               if (!fifo_empty_s) state_next_s = ISSUE; else state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // FSM output decode.
   always_comb begin
      mul_en_s    = 1'b0;
      rsp_valid_s = 1'b0;
      case (state_r)
         ISSUE:   mul_en_s    = 1'b1;
         RESP:    rsp_valid_s = 1'b1;
         default: begin
            mul_en_s    = 1'b0;
            rsp_valid_s = 1'b0;
         end
      endcase
   end

   // Operands and tag are loaded at pop and held until the next pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op1_r <= '0;
         op2_r <= '0;
         tag_r <= '0;
      end else if (pop_s) begin
         op1_r <= fifo_dout_s[WORD_W-1:0];
         op2_r <= fifo_dout_s[2*WORD_W-1:WORD_W];
         tag_r <= fifo_dout_s[ENTRY_W-1:2*WORD_W];
      end
   end

   // Watchdog and response capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_r    <= 8'd0;
         rsp_res_r <= '0;
         rsp_ovf_r <= 1'b0;
         rsp_err_r <= 1'b0;
         rsp_tag_r <= '0;
      end else begin
         case (state_r)
            ISSUE: wdog_r <= 8'd0;
            WAIT: begin
               if (mul_val) begin
                  rsp_res_r <= mul_res;
                  rsp_ovf_r <= mul_ovf;
                  rsp_err_r <= 1'b0;
                  rsp_tag_r <= tag_r;
               end else if (wdog_expired_s) begin
                  rsp_res_r <= '0;
                  rsp_ovf_r <= 1'b0;
                  rsp_err_r <= 1'b1;
                  rsp_tag_r <= tag_r;
               end else begin
                  wdog_r <= wdog_r + 8'd1;
               end
            end
            default: wdog_r <= wdog_r;
         endcase
      end
   end

   // Overflow event counter, counted on response handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count_r <= '0;
      end else if (rsp_hs_s && rsp_ovf_r) begin
         ovf_count_r <= sat_inc(ovf_count_r);
      end
   end

   assign req_ready = ~fifo_full_s;
   assign mul_en    = mul_en_s;
   assign mul_op1   = op1_r;
   assign mul_op2   = op2_r;
   assign rsp_valid = rsp_valid_s;
   assign rsp_res   = rsp_res_r;
   assign rsp_ovf   = rsp_ovf_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_tag   = rsp_tag_r;
   assign busy      = ~fifo_empty_s | (state_r != IDLE);
   assign ovf_count = ovf_count_r;

endmodule

// File: tb/tb_mul_req_sequencer.sv
// Self-checking bench for mul_req_sequencer: behavioural multiplier model with
// per-request latency, and a request-order scoreboard for the responses.
module tb_mul_req_sequencer;

   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 15;

   typedef struct {
      logic [31:0]      op1;
      logic [31:0]      op2;
      logic [TAG_W-1:0] tag;
      int               lat;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_op1;
   logic [31:0]      req_op2;
   logic [TAG_W-1:0] req_tag;
   logic             mul_en;
   logic [31:0]      mul_op1;
   logic [31:0]      mul_op2;
   logic [31:0]      mul_res;
   logic             mul_val;
   logic             mul_ovf;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_res;
   logic             rsp_ovf;
   logic             rsp_err;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
   logic [7:0]       ovf_count;

   int   total;
   int   bad;
   exp_t exp_q[$];
   int   lat_arr [0:1023];
   int   push_idx;
   int   issue_idx;
   int   lat;
   int   exp_ovf;

   logic        model_val;
   logic [31:0] model_res;
   logic        model_ovf;
   logic        stray_val;
   logic [31:0] stray_res;
   logic        stray_ovf;

   assign mul_val = model_val | stray_val;
   assign mul_res = model_val ? model_res : stray_res;
   assign mul_ovf = model_val ? model_ovf : stray_ovf;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mul_req_sequencer #(
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op1   (req_op1),
      .req_op2   (req_op2),
      .req_tag   (req_tag),
      .mul_en    (mul_en),
      .mul_op1   (mul_op1),
      .mul_op2   (mul_op2),
      .mul_res   (mul_res),
      .mul_val   (mul_val),
      .mul_ovf   (mul_ovf),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_ovf   (rsp_ovf),
      .rsp_err   (rsp_err),
      .rsp_tag   (rsp_tag),
      .busy      (busy),
      .ovf_count (ovf_count)
   );

   // Multiplier model: answers lat_arr[k] cycles after the k-th mul_en; 0 = never.
   initial begin : mul_model
      int          mlat;
      logic [63:0] prod;
      model_val = 1'b0;
      model_res = 32'd0;
      model_ovf = 1'b0;
      issue_idx = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            issue_idx = 0;
         end else if (mul_en) begin
            mlat = lat_arr[issue_idx];
            issue_idx++;
            prod = {32'd0, mul_op1} * {32'd0, mul_op2};
            if (mlat > 0) begin
               repeat (mlat) @(posedge clk);
               #1;
               model_val = 1'b1;
               model_res = prod[31:0];
               model_ovf = |prod[63:32];
               @(posedge clk);
               #1;
               model_val = 1'b0;
            end
         end
      end
   end

   initial begin : global_guard
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic record(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
      exp_t e;
      e.op1 = a;
      e.op2 = b;
      e.tag = t;
      e.lat = lat;
      exp_q.push_back(e);
      lat_arr[push_idx] = lat;
      push_idx++;
   endtask

   // Presents one request and waits (bounded) for its acceptance.
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_op1   = a;
      req_op2   = b;
      req_tag   = t;
      while (!req_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("push_ready", 64'(req_ready), 64'd1);
      if (req_ready) begin
         record(a, b, t);
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
   endtask

   // Waits for one response, checks it against the oldest expectation, consumes it.
   task automatic drain_one();
      int          n;
      exp_t        e;
      logic [63:0] p;
      logic        e_err;
      n = 0;
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rsp_arrive", 64'(rsp_valid), 64'd1);
      if (rsp_valid) begin
         check("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e     = exp_q.pop_front();
            p     = {32'd0, e.op1} * {32'd0, e.op2};
            e_err = (e.lat == 0) || (e.lat > TIMEOUT);
            check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            check("rsp_err", 64'(rsp_err), 64'(e_err));
            check("rsp_res", 64'(rsp_res), e_err ? 64'd0 : 64'(p[31:0]));
            check("rsp_ovf", 64'(rsp_ovf), e_err ? 64'd0 : 64'(|p[63:32]));
            check("mul_op1", 64'(mul_op1), 64'(e.op1));
            check("mul_op2", 64'(mul_op2), 64'(e.op2));
            if (!e_err && (|p[63:32]) && exp_ovf < 255) exp_ovf++;
         end
         @(posedge clk);
         #1;
         check("ovf_count", 64'(ovf_count), 64'(exp_ovf));
      end
      rsp_ready = 1'b0;
   endtask

   initial begin : stimulus
      int          n;
      int          acc;
      logic        seen;
      logic [31:0] held_res;
      logic [31:0] a;
      logic [31:0] b;
      total     = 0;
      bad       = 0;
      push_idx  = 0;
      exp_ovf   = 0;
      lat       = 2;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op1   = 32'd0;
      req_op2   = 32'd0;
      req_tag   = '0;
      rsp_ready = 1'b0;
      stray_val = 1'b0;
      stray_res = 32'hBAD0_BAD0;
      stray_ovf = 1'b1;
      for (int i = 0; i < 1024; i++) lat_arr[i] = 0;

      // Reset state
      #12;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_mul_en", 64'(mul_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ovf_count", 64'(ovf_count), 64'd0);
      check("rst_mul_op1", 64'(mul_op1), 64'd0);
      check("rst_rsp_res", 64'(rsp_res), 64'd0);
      check("rst_rsp_flags", {62'd0, rsp_err, rsp_ovf}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single op, latency 2
      lat = 2;
      push(32'd3, 32'd5, 4'd2);
      check("single_en_early", 64'(mul_en), 64'd0);
      n = 0;
      while (!mul_en && n < 10) begin @(posedge clk); #1; n++; end
      check("single_en_lat", 64'(n), 64'd1);
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("single_rsp_lat", 64'(n), 64'd4);
      check("single_res", 64'(rsp_res), 64'd15);
      check("single_tag", 64'(rsp_tag), 64'd2);
      drain_one();

      // Overflow op
      lat = 3;
      push(32'h0001_0000, 32'h0001_0000, 4'd1);
      drain_one();
      check("ovf_one", 64'(ovf_count), 64'd1);

      // Randomized batches
      for (int bt = 0; bt < 20; bt++) begin
         int k;
         lat = int'($urandom_range(0, TIMEOUT));
         k   = int'($urandom_range(1, 5));
         for (int i = 0; i < k; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'h0000_FFFF;
            if ($urandom_range(0, 1) == 0) b = b & 32'h0000_FFFF;
            push(a, b, TAG_W'($urandom));
         end
         for (int i = 0; i < k; i++) drain_one();
      end

      // Backpressure and full
      lat = 1;
      rsp_ready = 1'b0;
      acc = 0;
      n = 0;
      while (acc < 6 && n < 20) begin
         req_valid = 1'b1;
         req_op1   = 32'd10 + 32'(acc);
         req_op2   = 32'd3;
         req_tag   = TAG_W'(acc);
         if (req_ready) begin
            record(req_op1, req_op2, req_tag);
            acc++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = 1'b0;
      check("bp_accepts", 64'(acc), 64'd5);
      check("bp_ready_low", 64'(req_ready), 64'd0);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      held_res = rsp_res;
      repeat (3) @(posedge clk);
      #1;
      check("bp_hold_res", 64'(rsp_res), 64'(held_res));
      check("bp_hold_tag", 64'(rsp_tag), 64'd0);
      for (int i = 0; i < 5; i++) drain_one();
      check("bp_idle_busy", 64'(busy), 64'd0);
      check("bp_idle_ready", 64'(req_ready), 64'd1);

      // Timeout, then a normal op behind it
      lat = 0;
      push(32'd7, 32'd9, 4'd3);
      n = 0;
      while (!mul_en && n < 10) begin @(posedge clk); #1; n++; end
      check("to_en_seen", 64'(mul_en), 64'd1);
      n = 0;
      while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
      check("to_latency", 64'(n), 64'(TIMEOUT + 1));
      check("to_err", 64'(rsp_err), 64'd1);
      check("to_res", 64'(rsp_res), 64'd0);
      lat = 2;
      push(32'd6, 32'd7, 4'd4);
      drain_one();
      check("b2b_issue", 64'(mul_en), 64'd1);
      drain_one();

      // Result on the timeout cycle
      lat = TIMEOUT;
      push(32'd11, 32'd13, 4'd5);
      drain_one();

      // Stray val in IDLE and in RESP
      stray_val = 1'b1;
      @(posedge clk);
      #1;
      stray_val = 1'b0;
      @(posedge clk);
      #1;
      check("stray_idle_busy", 64'(busy), 64'd0);
      check("stray_idle_rsp", 64'(rsp_valid), 64'd0);
      lat = 1;
      push(32'd4, 32'd4, 4'd6);
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      stray_val = 1'b1;
      @(posedge clk);
      #1;
      stray_val = 1'b0;
      check("stray_resp_res", 64'(rsp_res), 64'd16);
      check("stray_resp_ovf", 64'(rsp_ovf), 64'd0);
      check("stray_resp_valid", 64'(rsp_valid), 64'd1);
      drain_one();

      // Overflow counter saturation
      lat = 1;
      for (int i = 0; i < 256; i++) begin
         push(32'h0001_0000, 32'h0002_0000, TAG_W'(i));
         drain_one();
      end
      check("ovf_saturated", 64'(ovf_count), 64'd255);

      // Asynchronous reset mid-WAIT with three queued
      lat = 0;
      push(32'd21, 32'd22, 4'd7);
      push(32'd23, 32'd24, 4'd8);
      push(32'd25, 32'd26, 4'd9);
      push(32'd27, 32'd28, 4'd10);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_ready", 64'(req_ready), 64'd1);
      check("arst_mul_op1", 64'(mul_op1), 64'd0);
      check("arst_ovf_count", 64'(ovf_count), 64'd0);
      exp_q.delete();
      push_idx = 0;
      exp_ovf  = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      stray_val = 1'b1;
      @(posedge clk);
      #1;
      stray_val = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (rsp_valid || mul_en) seen = 1'b1;
      end
      check("arst_no_rsp", 64'(seen), 64'd0);
      check("arst_idle_busy", 64'(busy), 64'd0);
      check("arst_idle_ready", 64'(req_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
